// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: burst read sequencer for a pipelined BRAM feeding a credit-guarded show-ahead skid FIFO
module bram_rd_streamer #(
    parameter int RD_ADDR_WDT = 10,
    parameter int DATA_WDT    = 64,
    parameter int RD_LAT      = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   cmd_start,
    input  logic [RD_ADDR_WDT-1:0] cmd_base_addr,
    input  logic [RD_ADDR_WDT:0]   cmd_len,
    output logic                   cmd_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   bram_rd_en,
    output logic [RD_ADDR_WDT-1:0] bram_rd_addr,
    input  logic [DATA_WDT-1:0]    bram_data_out,
    output logic [DATA_WDT-1:0]    m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [RD_ADDR_WDT:0] LEN_ONE = (RD_ADDR_WDT+1)'(1);

    if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_chk
        $fatal(1, "bram_rd_streamer: FIFO_DEPTH must be >= RD_LAT+1");
    end

    logic [1:0]             state;
    logic [RD_ADDR_WDT-1:0] addr, cur_addr;
    logic [RD_ADDR_WDT:0]   rem, cur_rem;
    logic [RD_LAT:0]        vld, tag;
    logic [DATA_WDT:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          fifo_cnt, inflight_cnt;
    logic                   accept, credit, issue, push, pop;

    // vld[0] is the issued read itself; vld[RD_LAT] lines up with valid BRAM data
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i <= RD_LAT; i++) inflight_cnt += CW'(vld[i]);
    end

    assign accept     = clk_en && state == IDLE && cmd_start;
    assign cur_addr   = accept ? cmd_base_addr : addr;
    assign cur_rem    = accept ? cmd_len : rem;
    assign credit     = fifo_cnt + inflight_cnt < CW'(FIFO_DEPTH);
    assign issue      = clk_en && cur_rem != '0 && (accept || (state == ISSUE && credit));
    assign push       = clk_en && vld[RD_LAT];
    assign pop        = clk_en && m_valid && m_ready;
    assign busy       = state != IDLE;
    assign cmd_ready  = !busy;
    assign bram_rd_en = vld[0];
    assign m_valid    = fifo_cnt != '0;
    assign {m_last, m_data} = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            rem          <= '0;
            vld          <= '0;
            tag          <= '0;
            bram_rd_addr <= '0;
            done         <= 1'b0;
        end else if (clk_en) begin
            vld   <= {vld[RD_LAT-1:0], issue};
            tag   <= {tag[RD_LAT-1:0], issue && cur_rem == LEN_ONE};
            done  <= (accept && cmd_len == '0) || (state == DRAIN && pop && m_last);
            state <= accept ? (cmd_len == '0 ? IDLE : cmd_len == LEN_ONE ? DRAIN : ISSUE)
                   : (issue && rem == LEN_ONE) ? DRAIN
                   : (state == DRAIN && pop && m_last) ? IDLE : state;
            if (issue) begin
                bram_rd_addr <= cur_addr;
                addr         <= cur_addr + RD_ADDR_WDT'(1);
                rem          <= cur_rem - LEN_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {tag[RD_LAT], bram_data_out};
                wr_ptr      <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end
endmodule
